// File: rtl/snake_move_ctrl_if.sv
// Button, game-step and move signals between the snake input stage and its neighbours.
// The master drives the raw pins and game events; the slave is the move controller.
interface snake_move_ctrl_if;
  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic       btn_pause;
  logic       step_tick;
  logic       game_over;
  logic [2:0] move;
  logic       animate;
  logic [1:0] state;

  modport master (
    output btn_up, btn_down, btn_left, btn_right, btn_pause, step_tick, game_over,
    input  move, animate, state
  );

  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, btn_pause, step_tick, game_over,
    output move, animate, state
  );
endinterface

// File: rtl/snake_move_ctrl.sv
// Push-button front end for the snake mover: synchronise, debounce, detect presses,
// reject reversals and apply turns on the game step, with run/pause/stop control.
module snake_move_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic               clk,
  input  logic               rst,
  snake_move_ctrl_if.slave   bus
);

  localparam int unsigned      NB       = 5;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_STOP  = 2'b11
  } state_t;

  // Bit order: 0 up, 1 down, 2 left, 3 right, 4 pause
  logic [NB-1:0]    w_pins;
  logic [NB-1:0]    r_sync1;
  logic [NB-1:0]    r_sync2;
  logic [NB-1:0]    r_deb;
  logic [NB-1:0]    r_deb_d;
  logic [NB-1:0]    r_press;
  logic [CNT_W-1:0] r_cnt [NB];

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_committed;
  logic [1:0] w_committed_nxt;
  logic [1:0] r_pending;
  logic [1:0] w_pending_nxt;
  logic [2:0] r_move;
  logic       r_animate;

  logic       w_dir_vld;
  logic [1:0] w_dir;
  logic       w_legal;

  assign w_pins = {bus.btn_pause, bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      r_deb_d <= '0;
      r_press <= '0;
      for (int unsigned i = 0; i < NB; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_pins;
      r_sync2 <= r_sync1;
      r_deb_d <= r_deb;
      r_press <= r_deb & ~r_deb_d;
      for (int unsigned i = 0; i < NB; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_deb[i] <= r_sync2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Priority up > down > left > right; lower-priority simultaneous presses are dropped
  always_comb begin
    w_dir_vld = |r_press[3:0];
    w_dir     = 2'b00;
    if (r_press[0])      w_dir = 2'b01;
    else if (r_press[1]) w_dir = 2'b11;
    else if (r_press[2]) w_dir = 2'b10;
    else                 w_dir = 2'b00;
  end

  // Checked against committed so two presses between steps cannot fold back on the body
  assign w_legal = w_dir_vld && (w_dir != (r_committed + 2'd2));

  always_comb begin
    w_state_nxt     = r_state;
    w_committed_nxt = r_committed;
    w_pending_nxt   = r_pending;
    case (r_state)
      S_IDLE: begin
        if (bus.game_over) begin
          w_state_nxt = S_STOP;
        end else if (w_legal) begin
          w_committed_nxt = w_dir;
          w_pending_nxt   = w_dir;
          w_state_nxt     = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.game_over) begin
          w_state_nxt = S_STOP;
        end else begin
          if (bus.step_tick) w_committed_nxt = r_pending;
          if (w_legal)       w_pending_nxt   = w_dir;
          if (r_press[4])    w_state_nxt     = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (bus.game_over)   w_state_nxt = S_STOP;
        else if (r_press[4]) w_state_nxt = S_RUN;
      end
      S_STOP: w_state_nxt = S_STOP;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_committed <= 2'b00;
      r_pending   <= 2'b00;
      r_move      <= 3'b100;
      r_animate   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_committed <= w_committed_nxt;
      r_pending   <= w_pending_nxt;
      r_move      <= (r_state == S_RUN) ? {1'b0, r_committed} : 3'b100;
      r_animate   <= (r_state == S_RUN);
    end
  end

  assign bus.move    = r_move;
  assign bus.animate = r_animate;
  assign bus.state   = r_state;

endmodule
